mandelbrot_raster: RTL and testbench

MANDELBROT_RASTER -- requirements
Module: mandelbrot_raster

---
 rtl/mandelbrot_raster.sv | 143 ++++++++++++++
 tb/tb_mandelbrot_raster.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_raster.sv
// Raster-scan pixel issuer for a pipelined Mandelbrot iterator chain.
// Issues (x,y) coordinates in raster order, one per cycle, and pairs each
// returning result packet with its coordinates via a matching delay line.
module mandelbrot_raster #(
  parameter logic [10:0] RESX    = 11'd640,
  parameter logic [10:0] RESY    = 11'd480,
  parameter int unsigned LATENCY = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pipe_ready,
  output logic [10:0] xout,
  output logic [10:0] yout,
  output logic [80:0] pinit,
  output logic        issue_valid,
  input  logic [80:0] pin,
  output logic        px_valid,
  output logic [10:0] px_x,
  output logic [10:0] px_y,
  output logic [15:0] px_iter,
  output logic        px_flag,
  output logic        busy,
  output logic        done
);

  localparam int unsigned LAST = LATENCY - 1;

  typedef enum logic [2:0] {IDLE, WAIT_READY, SCAN, DRAIN, DONE} state_t;

  state_t      state, state_next;
  logic [10:0] xcnt, ycnt;
  logic        last_issue;
  logic        last_result;
  logic        dl_v [LATENCY];
  logic [10:0] dl_x [LATENCY];
  logic [10:0] dl_y [LATENCY];

  // Only the flag and iteration fields of the result packet are consumed.
  logic unused_pin;
  assign unused_pin = ^pin[79:16];

  assign pinit       = '0;
  assign xout        = xcnt;
  assign yout        = ycnt;
  assign last_issue  = (xcnt == RESX - 11'd1) && (ycnt == RESY - 11'd1);
  assign last_result = px_valid && (px_x == RESX - 11'd1) && (px_y == RESY - 11'd1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_next  = state;
    issue_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = WAIT_READY;
      end
      WAIT_READY: begin
        busy = 1'b1;
        if (pipe_ready) state_next = SCAN;
      end
      SCAN: begin
        busy        = 1'b1;
        issue_valid = 1'b1;
        if (last_issue) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_result) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Raster counters: cleared while waiting for the pipe, frozen on the final pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xcnt <= '0;
      ycnt <= '0;
    end else if (state == WAIT_READY) begin
      xcnt <= '0;
      ycnt <= '0;
    end else if (state == SCAN && !last_issue) begin
      if (xcnt == RESX - 11'd1) begin
        xcnt <= '0;
        ycnt <= ycnt + 11'd1;
      end else begin
        xcnt <= xcnt + 11'd1;
      end
    end
  end

  // Coordinate delay line matching the iterator chain depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        dl_v[i] <= 1'b0;
        dl_x[i] <= '0;
        dl_y[i] <= '0;
      end
    end else begin
      dl_v[0] <= issue_valid;
      dl_x[0] <= xcnt;
      dl_y[0] <= ycnt;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_x[i] <= dl_x[i-1];
        dl_y[i] <= dl_y[i-1];
      end
    end
  end

  // Result register: pair the returning packet with its delayed coordinates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_valid <= 1'b0;
      px_x     <= '0;
      px_y     <= '0;
      px_iter  <= '0;
      px_flag  <= 1'b0;
    end else begin
      px_valid <= dl_v[LAST];
      if (dl_v[LAST]) begin
        px_x    <= dl_x[LAST];
        px_y    <= dl_y[LAST];
        px_iter <= pin[15:0];
        px_flag <= pin[80];
      end
    end
  end

endmodule

// File: tb/tb_mandelbrot_raster.sv
// Bench for mandelbrot_raster: a 4x2/latency-3 instance with a scoreboard
// and a timing table, plus a 1x1/latency-1 instance for the minimal frame.
module tb_mandelbrot_raster;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, pipe_ready = 1'b0;
  logic [80:0] pin = '0;
  logic [10:0] xout, yout, px_x, px_y;
  logic [80:0] pinit;
  logic        issue_valid, px_valid, px_flag, busy, done;
  logic [15:0] px_iter;

  logic        start1 = 1'b0, pr1 = 1'b1;
  logic [80:0] pin1 = {1'b1, 64'h0, 16'h1234};
  logic [10:0] xout1, yout1, px_x1, px_y1;
  logic [80:0] pinit1;
  logic        iv1, pxv1, px_flag1, busy1, done1;
  logic [15:0] px_iter1;

  mandelbrot_raster #(.RESX(11'd4), .RESY(11'd2), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .start(start), .pipe_ready(pipe_ready),
    .xout(xout), .yout(yout), .pinit(pinit), .issue_valid(issue_valid),
    .pin(pin), .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
    .px_iter(px_iter), .px_flag(px_flag), .busy(busy), .done(done)
  );

  mandelbrot_raster #(.RESX(11'd1), .RESY(11'd1), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pipe_ready(pr1),
    .xout(xout1), .yout(yout1), .pinit(pinit1), .issue_valid(iv1),
    .pin(pin1), .px_valid(pxv1), .px_x(px_x1), .px_y(px_y1),
    .px_iter(px_iter1), .px_flag(px_flag1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  int gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  int nvec = 0, nerr = 0, npx = 0, ndone = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_iter(input logic [10:0] x, input logic [10:0] y);
    if (x == 11'd2 && y == 11'd1) return 16'h000F;
    return {y[7:0], x[7:0]} ^ 16'h5A00;
  endfunction

  function automatic logic exp_flag(input logic [10:0] x, input logic [10:0] y);
    return x[0] ^ y[0];
  endfunction

  typedef struct {
    logic [10:0] x, y;
    logic [15:0] it;
    logic        f;
    int          due;
  } exp_t;
  typedef struct {
    logic [10:0] x, y;
    int          cyc;
  } iss_t;
  exp_t sb[$];
  iss_t pend[$];

  // Scoreboard: record issues, feed the iterator model, compare results.
  always @(negedge clk) begin
    exp_t e;
    iss_t p;
    if (!rst) begin
      if (done) ndone++;
      if (px_valid) begin
        npx++;
        if (sb.size() == 0) begin
          check("px_unexpected", {px_x, px_y}, 64'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("px_fields", {px_x, px_y, px_iter, px_flag}, {e.x, e.y, e.it, e.f});
          check("px_latency", gcyc, e.due);
        end
      end
      if (issue_valid) begin
        pend.push_back('{x: xout, y: yout, cyc: gcyc});
        sb.push_back('{x: xout, y: yout, it: exp_iter(xout, yout), f: exp_flag(xout, yout), due: gcyc + L + 1});
      end
      if (pend.size() > 0 && pend[0].cyc + L == gcyc) begin
        p = pend.pop_front();
        pin = {exp_flag(p.x, p.y), $urandom(), $urandom(), exp_iter(p.x, p.y)};
      end else begin
        pin = {$urandom(), $urandom(), $urandom()};
      end
    end
  end

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) break;
      tick();
    end
    check("done_reached", done, 1'b1);
  endtask

  typedef struct {
    logic        iv;
    logic [10:0] x, y;
    logic        pxv, busy, done;
  } vec_t;
  vec_t tbl[16];

  function automatic vec_t mk(input logic iv, input int x, input int y,
                              input logic pxv, input logic b, input logic d);
    vec_t v;
    v.iv = iv; v.x = 11'(x); v.y = 11'(y); v.pxv = pxv; v.busy = b; v.done = d;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0, d0;
    logic found;

    tbl[0]  = mk(0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 1, 0);
    tbl[2]  = mk(1, 0, 0, 0, 1, 0);
    tbl[3]  = mk(1, 1, 0, 0, 1, 0);
    tbl[4]  = mk(1, 2, 0, 0, 1, 0);
    tbl[5]  = mk(1, 3, 0, 0, 1, 0);
    tbl[6]  = mk(1, 0, 1, 1, 1, 0);
    tbl[7]  = mk(1, 1, 1, 1, 1, 0);
    tbl[8]  = mk(1, 2, 1, 1, 1, 0);
    tbl[9]  = mk(1, 3, 1, 1, 1, 0);
    tbl[10] = mk(0, 3, 1, 1, 1, 0);
    tbl[11] = mk(0, 3, 1, 1, 1, 0);
    tbl[12] = mk(0, 3, 1, 1, 1, 0);
    tbl[13] = mk(0, 3, 1, 1, 1, 0);
    tbl[14] = mk(0, 3, 1, 0, 0, 1);
    tbl[15] = mk(0, 3, 1, 0, 0, 0);

    // Reset state, with the clock running.
    tick(); tick();
    check("reset_outputs",
          {issue_valid, xout, yout, px_valid, px_x, px_y, px_iter, px_flag, busy, done},
          '0);
    check("reset_pinit", pinit[63:0] | {47'd0, pinit[80:64]}, '0);
    rst = 1'b0;
    tick(); tick(); tick();
    check("idle_without_start", {busy, issue_valid}, 2'b00);

    // Nominal 4x2 frame against the timing table.
    pipe_ready = 1'b1;
    npx = 0;
    start = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 1) start = 1'b0;
      check($sformatf("table_cycle%0d", c),
            {issue_valid, xout, yout, px_valid, busy, done},
            {tbl[c].iv, tbl[c].x, tbl[c].y, tbl[c].pxv, tbl[c].busy, tbl[c].done});
      tick();
    end
    check("frame1_px_count", npx, 8);

    // Pipe not ready for five cycles after start.
    pipe_ready = 1'b0;
    npx = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("stall_cycle%0d", c), {issue_valid, busy}, 2'b01);
      tick();
    end
    pipe_ready = 1'b1;
    check("ready_rise_cycle", {issue_valid, busy}, 2'b01);
    tick();
    check("first_issue_after_ready", {issue_valid, xout, yout}, {1'b1, 11'd0, 11'd0});
    pipe_ready = 1'b0;
    wait_done(40);
    tick();
    check("stall_frame_px_count", npx, 8);
    pipe_ready = 1'b1;

    // Reset in the middle of the scan at pixel (1,1).
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (issue_valid && xout == 11'd1 && yout == 11'd1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("reached_pixel_1_1", found, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_outputs_zero",
          {issue_valid, xout, yout, px_valid, px_x, px_y, px_iter, px_flag, busy, done},
          '0);
    sb.delete();
    pend.delete();
    tick(); tick();
    rst = 1'b0;
    n0 = npx;
    d0 = ndone;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0) break;
      tick();
    end
    check("abort_busy_low", busy, 1'b0);
    check("abort_no_px", npx - n0, 0);
    check("abort_no_done", ndone - d0, 0);

    npx = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40);
    tick();
    check("post_abort_px_count", npx, 8);

    // Start held high across a frame: no restart before IDLE.
    npx = 0;
    d0 = ndone;
    start = 1'b1;
    tick();
    wait_done(40);
    tick();
    check("held_start_idle_cycle", {busy, done, issue_valid}, 3'b000);
    tick();
    check("held_start_restart", {busy, issue_valid}, 2'b10);
    start = 1'b0;
    wait_done(40);
    tick();
    check("held_start_done_count", ndone - d0, 2);
    check("held_start_px_count", npx, 16);
    check("scoreboard_empty", sb.size(), 0);

    // Minimal 1x1 frame with latency 1.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("one_c1", {iv1, busy1, pxv1, done1}, 4'b0100);
    tick();
    check("one_c2_issue", {iv1, xout1, yout1, busy1}, {1'b1, 11'd0, 11'd0, 1'b1});
    tick();
    check("one_c3_drain", {iv1, pxv1, busy1, done1}, 4'b0010);
    tick();
    check("one_c4_px", {pxv1, px_x1, px_y1, px_iter1, px_flag1, done1},
          {1'b1, 11'd0, 11'd0, 16'h1234, 1'b1, 1'b0});
    tick();
    check("one_c5_done", {done1, busy1, pxv1}, 3'b100);
    tick();
    check("one_c6_idle", {done1, busy1, iv1}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
